// File: rtl/mips_id_stage.sv
// MIPS instruction-decode stage: IF/ID register, field decode,
// 32x32 register file and immediate sign extension.
module mips_id_stage #(
  parameter int NREGS = 32,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instruction32,
  input  logic [WIDTH-1:0] writeData,
  input  logic             regDst,
  input  logic             regWrite,
  output logic [WIDTH-1:0] readData1,
  output logic [WIDTH-1:0] readData2,
  output logic [WIDTH-1:0] extImmediate,
  output logic [5:0]       opcode,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [5:0]       funct,
  output logic [15:0]      immediate,
  output logic [25:0]      address
);

  localparam int AW = $clog2(NREGS);

  logic [31:0]      ir;
  logic [WIDTH-1:0] regs [NREGS];
  logic [AW-1:0]    wa;

  // IF/ID instruction register
  always_ff @(posedge clk) begin
    if (reset) ir <= '0;
    else       ir <= instruction32;
  end

  assign opcode    = ir[31:26];
  assign rs        = ir[25:21];
  assign rt        = ir[20:16];
  assign rd        = ir[15:11];
  assign shamt     = ir[10:6];
  assign funct     = ir[5:0];
  assign immediate = ir[15:0];
  assign address   = ir[25:0];

  assign extImmediate = {{(WIDTH-16){ir[15]}}, ir[15:0]};

  // destination comes from the instruction held before the edge
  assign wa = regDst ? rd : rt;

  // register file: reset clears all, r0 is never written
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (regWrite && wa != '0) begin
      regs[wa] <= writeData;
    end
  end

  assign readData1 = (rs == '0) ? '0 : regs[rs];
  assign readData2 = (rt == '0) ? '0 : regs[rt];

endmodule

// File: tb/tb_mips_id_stage.sv
// Self-checking bench for mips_id_stage.
// Expected state is queued at drive time and compared after the edge.
module tb_mips_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction32;
  logic [31:0] writeData;
  logic        regDst;
  logic        regWrite;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [31:0] extImmediate;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] immediate;
  logic [25:0] address;

  mips_id_stage dut (
    .clk(clk),
    .reset(reset),
    .instruction32(instruction32),
    .writeData(writeData),
    .regDst(regDst),
    .regWrite(regWrite),
    .readData1(readData1),
    .readData2(readData2),
    .extImmediate(extImmediate),
    .opcode(opcode),
    .rs(rs),
    .rt(rt),
    .rd(rd),
    .shamt(shamt),
    .funct(funct),
    .immediate(immediate),
    .address(address)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] rd1;
    logic [31:0] rd2;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mir;
  logic [31:0] mregs [32];
  int          checks = 0;
  int          failures = 0;

  // drive one cycle, advance the model, queue the expected state
  task automatic step(input logic [31:0] ins, input logic [31:0] wd,
                      input logic dst, input logic we, input logic rst);
    exp_t       e;
    logic [4:0] wa;
    instruction32 = ins;
    writeData     = wd;
    regDst        = dst;
    regWrite      = we;
    reset         = rst;
    wa = dst ? mir[15:11] : mir[20:16];
    if (rst) begin
      mir = '0;
      for (int i = 0; i < 32; i++) mregs[i] = '0;
    end else begin
      if (we && wa != 5'd0) mregs[wa] = wd;
      mir = ins;
    end
    e.ir  = mir;
    e.rd1 = mregs[mir[25:21]];
    e.rd2 = mregs[mir[20:16]];
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    mir = 32'hFFFF_FFFF;
    step(32'hFFFF_FFFF, 32'hA5A5_A5A5, 1'b1, 1'b1, 1'b1);
    e = sbq.pop_front();
    checks++;
    if ({opcode, address} !== 32'h0 || e.ir !== 32'h0) begin
      failures++;
      $display("FAIL reset_ir got=%h want=0", {opcode, address});
    end
    checks++;
    if (extImmediate !== 32'h0 || shamt !== 5'h0 || funct !== 6'h0) begin
      failures++;
      $display("FAIL reset_fields ext=%h shamt=%h funct=%h want 0",
               extImmediate, shamt, funct);
    end
    checks++;
    if (readData1 !== 32'h0 || readData2 !== 32'h0) begin
      failures++;
      $display("FAIL reset_read rd1=%h rd2=%h want 0", readData1, readData2);
    end
  endtask

  task automatic test_decode_lw();
    exp_t e;
    step(32'h8C22_0004, 32'h0, 1'b0, 1'b0, 1'b0);
    e = sbq.pop_front();
    checks++;
    if (opcode !== 6'b100011 || rs !== 5'd1 || rt !== 5'd2 || rd !== 5'd0) begin
      failures++;
      $display("FAIL lw_regs op=%b rs=%0d rt=%0d rd=%0d want 100011/1/2/0",
               opcode, rs, rt, rd);
    end
    checks++;
    if (immediate !== 16'h0004 || extImmediate !== 32'h0000_0004) begin
      failures++;
      $display("FAIL lw_imm imm=%h ext=%h want 0004/00000004",
               immediate, extImmediate);
    end
    checks++;
    if (address !== 26'h022_0004 || address !== e.ir[25:0]) begin
      failures++;
      $display("FAIL lw_addr got=%h want=0220004", address);
    end
  endtask

  task automatic test_sign_ext();
    step(32'h2001_FFFF, 32'h0, 1'b0, 1'b0, 1'b0);
    void'(sbq.pop_front());
    checks++;
    if (extImmediate !== 32'hFFFF_FFFF || immediate !== 16'hFFFF || rt !== 5'd1) begin
      failures++;
      $display("FAIL sign_ext ext=%h imm=%h rt=%0d want FFFFFFFF/FFFF/1",
               extImmediate, immediate, rt);
    end
  endtask

  task automatic test_write_rd();
    exp_t e;
    step(32'h0022_1820, 32'h0, 1'b0, 1'b0, 1'b0);
    void'(sbq.pop_front());
    step(32'h0060_0000, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
    e = sbq.pop_front();
    checks++;
    if (readData1 !== 32'hDEAD_BEEF || readData1 !== e.rd1) begin
      failures++;
      $display("FAIL write_rd rd1=%h want=DEADBEEF", readData1);
    end
    checks++;
    if (readData2 !== 32'h0) begin
      failures++;
      $display("FAIL write_rd_r0 rd2=%h want=0", readData2);
    end
  endtask

  task automatic test_write_rt();
    step(32'h0022_1820, 32'h0, 1'b0, 1'b0, 1'b0);
    void'(sbq.pop_front());
    step(32'h0022_1820, 32'h1234_5678, 1'b0, 1'b1, 1'b0);
    void'(sbq.pop_front());
    checks++;
    if (readData2 !== 32'h1234_5678) begin
      failures++;
      $display("FAIL write_rt rd2=%h want=12345678", readData2);
    end
    step(32'h0060_0000, 32'h0, 1'b0, 1'b0, 1'b0);
    void'(sbq.pop_front());
    checks++;
    if (readData1 !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL write_rt_r3 rd1=%h want=DEADBEEF", readData1);
    end
  endtask

  task automatic test_reg_zero();
    step(32'h0000_0000, 32'h0, 1'b0, 1'b0, 1'b0);
    void'(sbq.pop_front());
    step(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    void'(sbq.pop_front());
    step(32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    void'(sbq.pop_front());
    checks++;
    if (readData1 !== 32'h0 || readData2 !== 32'h0) begin
      failures++;
      $display("FAIL reg_zero rd1=%h rd2=%h want 0", readData1, readData2);
    end
  endtask

  task automatic test_no_write();
    step(32'h0022_1820, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0);
    void'(sbq.pop_front());
    step(32'h0022_1820, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
    void'(sbq.pop_front());
    checks++;
    if (readData1 !== 32'h0 || readData2 !== 32'h1234_5678) begin
      failures++;
      $display("FAIL no_write rd1=%h rd2=%h want 0/12345678",
               readData1, readData2);
    end
  endtask

  task automatic test_reset_midrun();
    step(32'h0062_0000, 32'h5555_5555, 1'b1, 1'b1, 1'b1);
    void'(sbq.pop_front());
    step(32'h0062_0000, 32'h0, 1'b0, 1'b0, 1'b0);
    void'(sbq.pop_front());
    checks++;
    if (readData1 !== 32'h0 || readData2 !== 32'h0) begin
      failures++;
      $display("FAIL reset_midrun rd1=%h rd2=%h want 0", readData1, readData2);
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [31:0] ins;
    for (int n = 0; n < 200; n++) begin
      ins = $urandom;
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
      ins[15:11] = 5'($urandom_range(0, 7));
      step(ins, $urandom, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 30) == 0));
      e = sbq.pop_front();
      checks++;
      if ({opcode, rs, rt, rd, shamt, funct} !== e.ir ||
          immediate !== e.ir[15:0] || address !== e.ir[25:0] ||
          extImmediate !== {{16{e.ir[15]}}, e.ir[15:0]}) begin
        failures++;
        $display("FAIL b2b_fields n=%0d op=%h rs=%h rt=%h ext=%h want ir=%h",
                 n, opcode, rs, rt, extImmediate, e.ir);
      end
      checks++;
      if (readData1 !== e.rd1 || readData2 !== e.rd2) begin
        failures++;
        $display("FAIL b2b_read n=%0d rd1=%h rd2=%h want %h/%h",
                 n, readData1, readData2, e.rd1, e.rd2);
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    instruction32 = 32'hFFFF_FFFF;
    writeData     = '0;
    regDst        = 1'b0;
    regWrite      = 1'b1;
    test_reset();
    test_decode_lw();
    test_sign_ext();
    test_write_rd();
    test_write_rt();
    test_reg_zero();
    test_no_write();
    test_reset_midrun();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
